// File: rtl/cpu8_core.sv
// Single-cycle 8-bit core: fetches from an external combinational ROM at pc,
// executes ADD/LW/SW/J against a 4x8 register file and a small data memory.
module cpu8_core #(
  parameter int DMEM_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] instruction,
  output logic [7:0] pc,
  input  logic [1:0] dbg_sel,
  output logic [7:0] dbg_reg,
  output logic       wb_valid,
  output logic [7:0] wb_data,
  output logic [7:0] retire_cnt
);

  localparam int AW = $clog2(DMEM_DEPTH);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_LW  = 2'b01;
  localparam logic [1:0] OP_SW  = 2'b10;
  localparam logic [1:0] OP_J   = 2'b11;

  logic [7:0] pc_q, pc_d;
  logic [7:0] rf_q [4];
  logic [7:0] rf_d [4];
  logic [7:0] dmem_q [DMEM_DEPTH];
  logic [7:0] dmem_d [DMEM_DEPTH];
  logic       wb_valid_q, wb_valid_d;
  logic [7:0] wb_data_q, wb_data_d;
  logic [7:0] retire_cnt_q, retire_cnt_d;

  logic [1:0]    op_s, rs_s, rt_s, rd_s;
  logic [7:0]    imm2_s, imm6_s;
  logic [7:0]    rs_val_s, rt_val_s, addr_s, ld_val_s, pc_inc_s;
  logic [AW-1:0] idx_s;

  // Instruction decode and combinational datapath (reads see pre-edge state)
  always_comb begin
    op_s     = instruction[7:6];
    rs_s     = instruction[5:4];
    rt_s     = instruction[3:2];
    rd_s     = instruction[1:0];
    imm2_s   = {{6{instruction[1]}}, instruction[1:0]};
    imm6_s   = {{2{instruction[5]}}, instruction[5:0]};
    rs_val_s = rf_q[rs_s];
    rt_val_s = rf_q[rt_s];
    addr_s   = rs_val_s + imm2_s;
    idx_s    = addr_s[AW-1:0];
    ld_val_s = dmem_q[idx_s];
    pc_inc_s = pc_q + 8'd1;
  end

  // Next-state computation; nothing changes unless en is high
  always_comb begin
    pc_d         = pc_q;
    rf_d         = rf_q;
    dmem_d       = dmem_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = wb_data_q;
    retire_cnt_d = retire_cnt_q;
    if (en) begin
      pc_d         = pc_inc_s;
      retire_cnt_d = retire_cnt_q + 8'd1;
      case (op_s)
        OP_ADD: begin
          rf_d[rd_s] = rs_val_s + rt_val_s;
          wb_valid_d = 1'b1;
          wb_data_d  = rs_val_s + rt_val_s;
        end
        OP_LW: begin
          rf_d[rt_s] = ld_val_s;
          wb_valid_d = 1'b1;
          wb_data_d  = ld_val_s;
        end
        OP_SW: begin
          dmem_d[idx_s] = rt_val_s;
        end
        OP_J: begin
          pc_d = pc_inc_s + imm6_s;
        end
        default: begin
          pc_d = pc_inc_s;
        end
      endcase
    end else begin
      pc_d = pc_q;
    end
  end

  // Architectural state; reset reloads the register and memory identity patterns
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= 8'h00;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= 8'h00;
      retire_cnt_q <= 8'h00;
      for (int i = 0; i < 4; i++) rf_q[i] <= 8'(i);
      for (int i = 0; i < DMEM_DEPTH; i++) dmem_q[i] <= 8'(i);
    end else begin
      pc_q         <= pc_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      retire_cnt_q <= retire_cnt_d;
      rf_q         <= rf_d;
      dmem_q       <= dmem_d;
    end
  end

  assign pc         = pc_q;
  assign dbg_reg    = rf_q[dbg_sel];
  assign wb_valid   = wb_valid_q;
  assign wb_data    = wb_data_q;
  assign retire_cnt = retire_cnt_q;

endmodule

// File: tb/tb_cpu8_core.sv
// Directed-vector bench for cpu8_core; the bench plays the ROM by driving
// instruction directly and checks architectural state via the debug port.
module tb_cpu8_core;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic [7:0] instruction = 8'h00;
  logic [7:0] pc;
  logic [1:0] dbg_sel = 2'd0;
  logic [7:0] dbg_reg;
  logic       wb_valid;
  logic [7:0] wb_data;
  logic [7:0] retire_cnt;

  int errors = 0;
  int checks = 0;

  cpu8_core #(.DMEM_DEPTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .instruction(instruction), .pc(pc),
    .dbg_sel(dbg_sel), .dbg_reg(dbg_reg), .wb_valid(wb_valid),
    .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    en = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  task automatic step(input logic [7:0] ins, input logic e);
    instruction = ins;
    en = e;
    @(posedge clk);
    #1;
  endtask

  task automatic rd_reg(input logic [1:0] sel, output logic [7:0] v);
    dbg_sel = sel;
    #0.5;
    v = dbg_reg;
  endtask

  task automatic test_reset();
    logic [7:0] v;
    do_reset();
    #1;
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL reset_pc: got %h want 00", pc); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL reset_wb_valid: got %b want 0", wb_valid); end
    checks++; if (wb_data !== 8'h00) begin errors++; $display("FAIL reset_wb_data: got %h want 00", wb_data); end
    checks++; if (retire_cnt !== 8'h00) begin errors++; $display("FAIL reset_retire: got %h want 00", retire_cnt); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      checks++; if (v !== 8'(i)) begin errors++; $display("FAIL reset_r%0d: got %h want %h", i, v, 8'(i)); end
    end
  endtask

  task automatic test_add();
    logic [7:0] v;
    do_reset();
    step(8'h1B, 1'b1);  // r3 <- r1 + r2 = 3
    rd_reg(2'd3, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL add_r3: got %h want 03", v); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL add_pc: got %h want 01", pc); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL add_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_data !== 8'h03) begin errors++; $display("FAIL add_wb_data: got %h want 03", wb_data); end
    checks++; if (retire_cnt !== 8'h01) begin errors++; $display("FAIL add_retire: got %h want 01", retire_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] v;
    // continues from test_add: r3 = 3; r3 <- r3 + r3 uses the old r3
    step(8'h3F, 1'b1);
    rd_reg(2'd3, v);
    checks++; if (v !== 8'h06) begin errors++; $display("FAIL b2b_r3: got %h want 06", v); end
    checks++; if (wb_data !== 8'h06) begin errors++; $display("FAIL b2b_wb_data: got %h want 06", wb_data); end
    checks++; if (retire_cnt !== 8'h02) begin errors++; $display("FAIL b2b_retire: got %h want 02", retire_cnt); end
  endtask

  task automatic test_sw_lw();
    logic [7:0] v;
    do_reset();
    step(8'h8C, 1'b1);  // dmem[0] <- r3 (3)
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL sw_wb_valid: got %b want 0", wb_valid); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL sw_pc: got %h want 01", pc); end
    rd_reg(2'd3, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL sw_r3: got %h want 03", v); end
    step(8'h44, 1'b1);  // r1 <- dmem[0]
    rd_reg(2'd1, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL lw_r1: got %h want 03", v); end
    checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL lw_wb_valid: got %b want 1", wb_valid); end
    checks++; if (wb_data !== 8'h03) begin errors++; $display("FAIL lw_wb_data: got %h want 03", wb_data); end
    checks++; if (retire_cnt !== 8'h02) begin errors++; $display("FAIL lw_retire: got %h want 02", retire_cnt); end
  endtask

  task automatic test_lw_wrap();
    logic [7:0] v;
    do_reset();
    step(8'h43, 1'b1);  // r0 <- dmem[0xFF -> 31]
    rd_reg(2'd0, v);
    checks++; if (v !== 8'h1F) begin errors++; $display("FAIL lw_wrap_r0: got %h want 1f", v); end
    checks++; if (wb_data !== 8'h1F) begin errors++; $display("FAIL lw_wrap_wb_data: got %h want 1f", wb_data); end
  endtask

  task automatic test_jump();
    logic [7:0] v;
    do_reset();
    step(8'hC4, 1'b1);  // pc 0 -> 5
    checks++; if (pc !== 8'h05) begin errors++; $display("FAIL j_fwd_pc: got %h want 05", pc); end
    step(8'hFE, 1'b1);  // pc 5 -> 4
    checks++; if (pc !== 8'h04) begin errors++; $display("FAIL j_back_pc: got %h want 04", pc); end
    step(8'hF9, 1'b1);  // pc 4 -> fe
    checks++; if (pc !== 8'hFE) begin errors++; $display("FAIL j_neg_pc: got %h want fe", pc); end
    step(8'hC3, 1'b1);  // pc fe -> 02 (wrap)
    checks++; if (pc !== 8'h02) begin errors++; $display("FAIL j_wrap_pc: got %h want 02", pc); end
    checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL j_wb_valid: got %b want 0", wb_valid); end
    checks++; if (retire_cnt !== 8'h04) begin errors++; $display("FAIL j_retire: got %h want 04", retire_cnt); end
    for (int i = 0; i < 4; i++) begin
      rd_reg(2'(i), v);
      checks++; if (v !== 8'(i)) begin errors++; $display("FAIL j_r%0d: got %h want %h", i, v, 8'(i)); end
    end
  endtask

  task automatic test_en_hold();
    logic [7:0] v;
    do_reset();
    step(8'h06, 1'b1);  // r2 <- r0 + r1 = 1
    for (int k = 0; k < 3; k++) begin
      step(8'h1B, 1'b0);  // would set r3 <- 1 + 1 if executed
      checks++; if (pc !== 8'h01) begin errors++; $display("FAIL hold_pc%0d: got %h want 01", k, pc); end
      checks++; if (retire_cnt !== 8'h01) begin errors++; $display("FAIL hold_retire%0d: got %h want 01", k, retire_cnt); end
      checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL hold_wb_valid%0d: got %b want 0", k, wb_valid); end
      rd_reg(2'd3, v);
      checks++; if (v !== 8'h03) begin errors++; $display("FAIL hold_r3_%0d: got %h want 03", k, v); end
    end
    checks++; if (wb_data !== 8'h01) begin errors++; $display("FAIL hold_wb_data: got %h want 01", wb_data); end
  endtask

  task automatic test_reset_mid();
    logic [7:0] v;
    do_reset();
    step(8'h1B, 1'b1);  // r3 = 3
    step(8'h2F, 1'b1);  // r3 = 2 + 3 = 5
    step(8'h8C, 1'b1);  // dmem[0] = 5
    step(8'h34, 1'b1);  // r0 = 5 + 1 = 6
    checks++; if (pc !== 8'h04) begin errors++; $display("FAIL mid_pre_pc: got %h want 04", pc); end
    rd_reg(2'd0, v);
    checks++; if (v !== 8'h06) begin errors++; $display("FAIL mid_pre_r0: got %h want 06", v); end
    rst_n = 1'b0;
    rd_reg(2'd0, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_r0: got %h want 00", v); end
    rd_reg(2'd3, v);
    checks++; if (v !== 8'h03) begin errors++; $display("FAIL mid_r3: got %h want 03", v); end
    checks++; if (pc !== 8'h00) begin errors++; $display("FAIL mid_pc: got %h want 00", pc); end
    checks++; if (retire_cnt !== 8'h00) begin errors++; $display("FAIL mid_retire: got %h want 00", retire_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    step(8'h44, 1'b1);  // r1 <- dmem[0], restored to 0
    rd_reg(2'd1, v);
    checks++; if (v !== 8'h00) begin errors++; $display("FAIL mid_dmem0: got %h want 00", v); end
    checks++; if (pc !== 8'h01) begin errors++; $display("FAIL mid_post_pc: got %h want 01", pc); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_sw_lw();
    test_lw_wrap();
    test_jump();
    test_en_hold();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cpu8_core.md
# cpu8_core

Single-cycle 8-bit processor core that sits directly downstream of the lab instruction ROM. It drives the ROM address with its program counter, consumes the returned 8-bit instruction in the same cycle, and executes it. Execution uses a 4×8 register file, an 8-bit adder and a 32-byte data memory. Debug outputs expose architectural state to the board display logic.

## Interface
- `DMEM_DEPTH`, default 32: data memory entries. Index is address[4:0].
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: execute enable. While low, the core holds all state.
- `instruction`, input, 8: instruction from the ROM. It corresponds to the current `pc`, and the path from `pc` to `instruction` is combinational.
- `pc`, output, 8: program counter, which drives the ROM address.
- `dbg_sel`, input, 2: register index for the debug read port.
- `dbg_reg`, output, 8: combinational read of register `dbg_sel`.
- `wb_valid`, output, 1: registered; high for one cycle after an instruction writes a register.
- `wb_data`, output, 8: registered value of the last register write.
- `retire_cnt`, output, 8: number of executed instructions, wrapping modulo 256.

## Operation
- Instruction fields:
  - op = [7:6], rs = [5:4], rt = [3:2], rd = [1:0].
  - imm2 = [1:0], sign-extended to 8 bits.
  - imm6 = [5:0], sign-extended to 8 bits.
- op 00, ADD: r[rd] ← r[rs] + r[rt], modulo 256; carry is discarded.
- op 01, LW: r[rt] ← dmem[(r[rs] + sext(imm2))[4:0]].
- op 10, SW: dmem[(r[rs] + sext(imm2))[4:0]] ← r[rt]. No register write.
- op 11, J: pc ← pc + 1 + sext(imm6), modulo 256. No register or memory write.
- All non-J ops: pc ← pc + 1, wrapping 255 → 0.
- Address arithmetic is 8-bit with wrap-around; only bits [4:0] index dmem. Example: r[rs] = 0, imm2 = 11 gives address 0xFF, which maps to index 31.
- Register file:
  - Two combinational read ports (rs, rt) plus the debug port.
  - One write port, written on the clock edge.
  - A read of the register being written in the same cycle returns the old value.
- Data memory:
  - Combinational read, synchronous write.
  - An LW following an SW to the same address sees the stored value on the next cycle.
- With `en` = 0: no pc, register, dmem, counter or wb update; `wb_valid` drops to 0 on the next edge.
- Reset values, applied asynchronously whenever `rst_n` = 0:
  - pc = 0x00.
  - r0..r3 = 0x00, 0x01, 0x02, 0x03.
  - dmem[i] = i for i = 0..31.
  - wb_valid = 0, wb_data = 0x00, retire_cnt = 0x00.
- Reset asserted mid-execution: the instruction in flight is abandoned and no partial write occurs. After release, the first enabled edge executes `instruction` at pc 0.

## Timing
- Latency is one cycle per instruction. The ROM read, decode, ALU and dmem read are all combinational within the cycle.
- All writes commit on the single rising edge where `en` = 1.
- `pc` changes only on enabled edges. `instruction` must be settled before the next edge; it comes combinationally from ROM.
- `wb_valid`, `wb_data` and `retire_cnt` update on the same edge as the architectural write they report.
- `dbg_reg` reflects a write starting in the cycle after the edge that commits it.
- Reset release should be synchronous to `clk` externally. The core adds no synchronizer.

## Test plan
- Reset, then ADD 0x1B (r3 ← r1 + r2) with `en` = 1 → after 1 edge: r3 = 0x03, pc = 0x01, wb_valid = 1, wb_data = 0x03, retire_cnt = 1.
- SW 0x8C (dmem[r0 + 0] ← r3, with r3 = 3), then LW 0x44 (r1 ← dmem[r0 + 0]) → dmem[0] = 0x03, r1 = 0x03. After the SW edge wb_valid = 0; after the LW edge wb_valid = 1.
- LW 0x43 from reset (r0 ← dmem[r0 + (−1)]) → the address wraps to 0xFF, so r0 = dmem[31] = 0x1F.
- J with pc = 5, instruction 0xFE (offset −2) → pc = 0x04. J 0xC3 at pc 0xFE → pc wraps to 0x02; no register change.
- Hold `en` = 0 for 3 edges with ADD presented → pc, registers and retire_cnt are unchanged; wb_valid = 0.
- Assert `rst_n` low between edges after 4 instructions → pc = 0 and r0..r3 = 0, 1, 2, 3 immediately, with no clock needed; dmem[0] = 0 and retire_cnt = 0.
